cla_share_arb: RTL
==================

Name: cla_share_arb

Overview:
- Round-robin arbiter and sequencer sharing one `N-bit carry-lookahead adder among NREQ requesters.
- Each requester offers an operand pair and carry-in over a valid/ready handshake. The block grants one requester, latches its operands and drives them through the adder. It registers the sum and carry-out, then presents them with the winner's ID on a single result valid/ready port.
- Sits between several datapath clients and the adder instance it owns internally.

Parameters:
- W, default `N (8): adder operand and sum width; `N comes from params.vh.
- NREQ, default 4: number of requesters, 2..8.
- IDW, default 2: requester-ID width, equal to clog2(NREQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i offers an operation.
- req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  NREQ*W  operand B, packed like req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_ready  output  NREQ  one-hot or zero; bit i accepts requester i this cycle.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_sum  output  W  registered sum.
- res_cout  output  1  registered carry-out.
- res_id  output  IDW  index of requester that produced the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, mid-operation included): state=IDLE, rr_ptr=0.
  - Outputs: res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, req_ready=0.
  - Operand registers are cleared to 0.
  - An in-flight operation is discarded and is not replayed.
- FSM has three states:
  - IDLE:
    - Combinationally selects winner g, the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, …, NREQ-1, 0, … (wrap-around).
    - Drives req_ready = one-hot(g) when any req_valid is set, else 0.
    - On the handshake edge it latches a_r, b_r, cin_r and id_r=g, sets rr_ptr=(g+1) mod NREQ, and moves to CALC.
  - CALC: exactly one cycle.
    - Adder inputs are a_r, b_r, cin_r.
    - On the edge: res_sum ← sum, res_cout ← carry, res_id ← id_r, res_valid ← 1; move to DONE.
    - req_ready=0.
  - DONE: holds all res_* stable while res_valid=1 and res_ready=0.
    - On res_valid && res_ready: res_valid←0, move to IDLE.
    - req_ready=0. res_sum, res_cout and res_id keep their last values after the handshake.
- Latency: request handshake to res_valid=1 is 2 cycles.
  - Peak throughput is 1 operation per 3 cycles, because a new grant only happens in IDLE.
- Arithmetic: {res_cout, res_sum} = a + b + cin, computed modulo 2^(W+1). Operands are unsigned and there is no saturation.
- Boundary conditions:
  - All req_valid low: stay in IDLE, req_ready=0, rr_ptr unchanged.
  - req_valid deasserted before the grant: the request is simply not granted. Operands are sampled only on the handshake edge.
  - res_ready high during CALC: ignored. The result handshake is only honoured in DONE.
  - rr_ptr = NREQ-1 wraps to 0.
  - Requesters with indices ≥ NREQ do not exist.

Optional Feature:
- Macro: CLA_ARB_SUB_EN.
- When defined:
  - Adds input port req_sub [NREQ], latched as sub_r at the grant.
  - If sub_r=1, the adder computes a + ~b + 1: b_r is inverted and the carry-in is forced to 1, ignoring req_cin.
  - res_cout=1 means no borrow (a ≥ b).
  - Adds output res_sub (1 bit, reset 0), registered alongside res_sum.
- When undefined: no req_sub or res_sub ports; behaviour is addition only, as above.

Test Plan:
- Reset then single request: req_valid=0001, a0=0x3C, b0=0x45, cin=1.
  - Expect req_ready=0001 in the same cycle.
  - Two cycles later: res_valid=1, res_sum=0x82, res_cout=0, res_id=0.
- Carry-out and wrap: a=0xFF, b=0x01, cin=0 → res_sum=0x00, res_cout=1. Also a=0xFF, b=0xFF, cin=1 → res_sum=0xFF, res_cout=1.
- Round-robin fairness: hold req_valid=1111 continuously with res_ready=1.
  - Grant order: 0, 1, 2, 3, 0, …, with res_id following the same order.
  - Then req_valid=1010 after a grant to 3: next grants are 1, 3, 1.
- Backpressure: res_ready=0 for 5 cycles in DONE.
  - res_valid, res_sum and res_id stay stable; req_ready stays 0 throughout.
  - Releasing res_ready gives IDLE the next cycle and the next grant from IDLE.
- Reset mid-operation: assert rst during CALC.
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - After release, requester 0 has highest priority again.
- CLA_ARB_SUB_EN defined:
  - req_sub=1, a=0x10, b=0x20 → res_sum=0xF0, res_cout=0, res_sub=1.
  - a=0x20, b=0x10 → res_sum=0x10, res_cout=1.

Source files
------------

// File: rtl/cla_share_arb.sv
// ----------------------------------------------------------------------------
// cla_share_arb
//
// Round-robin arbiter and sequencer sharing one carry-lookahead adder among
// NREQ requesters. IDLE grants one requester and latches its operands. CALC
// drives them through the adder for one cycle and registers sum and carry-out.
// DONE presents the result on a valid/ready port until it is accepted.
//
// Optional feature macro: CLA_ARB_SUB_EN
//   When defined, this adds input req_sub and output res_sub. A granted
//   requester with req_sub=1 gets a - b, computed as a + ~b + 1. In that case
//   res_cout=1 means no borrow.
//
// Parameters:
//   W     operand and sum width (default `N, fallback 8)
//   NREQ  number of requesters, 2..8
//   IDW   requester-ID width, clog2(NREQ)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid
//   req_a      packed operand A, requester i at [i*W +: W]
//   req_b      packed operand B, same packing
//   req_cin    per-requester carry-in
//   req_sub    per-requester subtract select (CLA_ARB_SUB_EN only)
//   req_ready  one-hot grant / accept, zero outside IDLE
//   res_valid  result available
//   res_ready  consumer accepts result
//   res_sum    registered sum
//   res_cout   registered carry-out
//   res_id     index of the requester that produced the result
//   res_sub    result came from a subtraction (CLA_ARB_SUB_EN only)
//   busy       high in any state other than IDLE
// ----------------------------------------------------------------------------

`ifndef N
`define N 8
`endif

module cla_share_arb #(
    parameter int unsigned W    = `N,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
`ifdef CLA_ARB_SUB_EN
    input  logic [NREQ-1:0]   req_sub,
`endif
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id,
`ifdef CLA_ARB_SUB_EN
    output logic              res_sub,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         r_state;
    state_e         w_state_next;

    logic [IDW-1:0] r_rr_ptr;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_cin;
    logic           r_sub;
    logic [IDW-1:0] r_id;

    logic           r_res_valid;
    logic [W-1:0]   r_res_sum;
    logic           r_res_cout;
    logic [IDW-1:0] r_res_id;
    logic           r_res_sub;

    // ------------------------------------------------------------------------
    // Round-robin winner search
    // ------------------------------------------------------------------------
    logic           w_any_valid;
    logic [IDW-1:0] w_grant_id;
    logic [IDW-1:0] w_rr_next;

    // The scan runs from the farthest offset down to offset 0. The nearest
    // valid requester to r_rr_ptr is therefore the last one written and wins.
    always_comb begin
        logic [IDW:0] w_pos;
        w_any_valid = 1'b0;
        w_grant_id  = '0;
        w_pos       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
            if (w_pos >= (IDW + 1)'(NREQ)) begin
                w_pos = w_pos - (IDW + 1)'(NREQ);
            end
            if (req_valid[w_pos[IDW-1:0]]) begin
                w_any_valid = 1'b1;
                w_grant_id  = w_pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        if (w_grant_id == IDW'(NREQ - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_id + IDW'(1);
        end
    end

    // Operand select for the winner.
    logic [W-1:0] w_sel_a;
    logic [W-1:0] w_sel_b;
    logic         w_sel_cin;
    logic         w_sel_sub;

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == IDW'(i)) begin
                w_sel_a   = req_a[i*W +: W];
                w_sel_b   = req_b[i*W +: W];
                w_sel_cin = req_cin[i];
`ifdef CLA_ARB_SUB_EN
                w_sel_sub = req_sub[i];
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Carry-lookahead adder on the latched operands
    // ------------------------------------------------------------------------
    logic [W-1:0] w_add_b;
    logic         w_add_cin;
    logic [W-1:0] w_gen;
    logic [W-1:0] w_prop;
    logic [W:0]   w_carry;
    logic [W-1:0] w_sum;
    logic         w_cout;

    // Subtraction is a + ~b + 1. The requester's carry-in is ignored then.
    assign w_add_b   = r_sub ? ~r_b : r_b;
    assign w_add_cin = r_sub ? 1'b1 : r_cin;
    assign w_gen     = r_a & w_add_b;
    assign w_prop    = r_a ^ w_add_b;

    // Each carry is a flat sum of products of generate/propagate terms and cin.
    // No carry depends on the previous one.
    always_comb begin
        logic c_acc;
        logic p_acc;
        w_carry    = '0;
        w_carry[0] = w_add_cin;
        c_acc      = 1'b0;
        p_acc      = 1'b1;
        for (int i = 0; i < W; i++) begin
            c_acc = 1'b0;
            p_acc = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c_acc = c_acc | (p_acc & w_gen[j]);
                p_acc = p_acc & w_prop[j];
            end
            w_carry[i+1] = c_acc | (p_acc & w_add_cin);
        end
    end

    assign w_sum  = w_prop ^ w_carry[W-1:0];
    assign w_cout = w_carry[W];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    logic w_req_fire;
    logic w_res_fire;

    assign w_req_fire = (r_state == StIdle) && w_any_valid;
    assign w_res_fire = (r_state == StDone) && r_res_valid && res_ready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_any_valid) w_state_next = StCalc;
            StCalc: w_state_next = StDone;
            StDone: if (w_res_fire) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs. While reset is asserted, the grant is held low even in IDLE.
    always_comb begin
        req_ready = '0;
        busy      = (r_state != StIdle);
        if ((r_state == StIdle) && w_any_valid && !rst) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_sub    <= 1'b0;
            r_id     <= '0;
        end else if (w_req_fire) begin
            r_rr_ptr <= w_rr_next;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_cin    <= w_sel_cin;
            r_sub    <= w_sel_sub;
            r_id     <= w_grant_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
            r_res_sub   <= 1'b0;
        end else if (r_state == StCalc) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_cout  <= w_cout;
            r_res_id    <= r_id;
            r_res_sub   <= r_sub;
        end else if (w_res_fire) begin
            // Only valid drops. The result fields keep their values.
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
`ifdef CLA_ARB_SUB_EN
    assign res_sub   = r_res_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = r_res_sub;
`endif

endmodule
